// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC vectoring engine: (x, y) -> (K*|v|, atan2(y, x)), one micro-rotation per clock.
// Latency: accept at edge E, result registered and out_valid_o high after edge E+ITERATIONS.
// Backpressure: in_ready_o only in IDLE; the result holds in DONE until out_ready_i, then returns to IDLE.
module cordic_vector_iter #(
   parameter int WIDTH      = 21,
   parameter int FRAC       = 18,
   parameter int ITERATIONS = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_x_i,
   input  logic [WIDTH-1:0] in_y_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_mag_o,
   output logic [WIDTH-1:0] out_angle_o
);

   localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

   // pi/2 in the port format, rounded to nearest (411775 at FRAC = 18)
   localparam int HALF_PI_INT = int'(1.5707963267948966 * (2.0 ** FRAC));
   localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(HALF_PI_INT);

   // round(atan(2^-i) * 2^18); enough entries for the widest legal ITERATIONS
   function automatic int atan_q18(input int idx);
      case (idx)
         0:       atan_q18 = 205887;
         1:       atan_q18 = 121543;
         2:       atan_q18 = 64220;
         3:       atan_q18 = 32599;
         4:       atan_q18 = 16363;
         5:       atan_q18 = 8189;
         6:       atan_q18 = 4096;
         7:       atan_q18 = 2048;
         8:       atan_q18 = 1024;
         9:       atan_q18 = 512;
         10:      atan_q18 = 256;
         11:      atan_q18 = 128;
         12:      atan_q18 = 64;
         13:      atan_q18 = 32;
         14:      atan_q18 = 16;
         15:      atan_q18 = 8;
         16:      atan_q18 = 4;
         17:      atan_q18 = 2;
         18:      atan_q18 = 1;
         default: atan_q18 = 0;
      endcase
   endfunction

   // Rescale the Q.18 table to the configured fraction width (exact at FRAC = 18)
   function automatic int atan_scaled(input int idx);
      int t;
      t = atan_q18(idx);
      if (FRAC >= 18) atan_scaled = t <<< (FRAC - 18);
      else            atan_scaled = (t + (1 <<< (17 - FRAC))) >>> (18 - FRAC);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic signed [WIDTH-1:0]  x_q, y_q, z_q, x_d, y_d, z_d;
   logic        [WIDTH-1:0]  mag_q, ang_q, mag_d, ang_d;
   logic        [CNT_W-1:0]  cnt_q, cnt_d;
   logic                     zero_q, zero_d;
   logic                     accept, last_step;

   logic signed [WIDTH-1:0]  atan_lut [ITERATIONS];
   logic signed [WIDTH-1:0]  x0, y0, z0;
   logic signed [WIDTH-1:0]  x_sh, y_sh, x_step, y_step, z_step, atan_i;

   for (genvar g = 0; g < ITERATIONS; g++) begin : g_lut
      assign atan_lut[g] = WIDTH'(atan_scaled(g));
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign out_mag_o   = mag_q;
   assign out_angle_o = ang_q;

   // Control: state transitions and the accept / final-step strobes
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      last_step = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               accept  = 1'b1;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (cnt_q == LAST_STEP) begin
               last_step = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Quadrant fold into the right half-plane so the micro-rotations converge
   always_comb begin
      x0 = $signed(in_x_i);
      y0 = $signed(in_y_i);
      z0 = '0;
      if (in_x_i[WIDTH-1]) begin
         if (!in_y_i[WIDTH-1]) begin
            x0 = $signed(in_y_i);
            y0 = -$signed(in_x_i);
            z0 = HALF_PI;
         end else begin
            x0 = -$signed(in_y_i);
            y0 = $signed(in_x_i);
            z0 = -HALF_PI;
         end
      end
   end

   // One shift/add micro-rotation driving y toward zero, from the pre-step registers
   always_comb begin
      atan_i = atan_lut[cnt_q];
      x_sh   = x_q >>> cnt_q;
      y_sh   = y_q >>> cnt_q;
      if (!y_q[WIDTH-1]) begin
         x_step = x_q + y_sh;
         y_step = y_q - x_sh;
         z_step = z_q + atan_i;
      end else begin
         x_step = x_q - y_sh;
         y_step = y_q + x_sh;
         z_step = z_q - atan_i;
      end
   end

   // Datapath next state: load on accept, step in ITER, capture result on the final step
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      z_d    = z_q;
      cnt_d  = cnt_q;
      zero_d = zero_q;
      mag_d  = mag_q;
      ang_d  = ang_q;
      if (accept) begin
         x_d    = x0;
         y_d    = y0;
         z_d    = z0;
         cnt_d  = '0;
         zero_d = (in_x_i == '0) && (in_y_i == '0);
      end else if (state_q == S_ITER) begin
         x_d   = x_step;
         y_d   = y_step;
         z_d   = z_step;
         cnt_d = cnt_q + 1'b1;
         if (last_step) begin
            cnt_d = '0;
            mag_d = zero_q ? '0 : x_step;
            ang_d = zero_q ? '0 : z_step;
         end
      end
   end

   // State and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         mag_q   <= '0;
         ang_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         mag_q   <= mag_d;
         ang_q   <= ang_d;
      end
   end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Directed-vector bench for the iterative CORDIC vectoring engine.
// Table of (x, y) inputs with hand-computed magnitude/angle, plus backpressure and mid-run reset sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_cordic_vector_iter;
   localparam int W = 21;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [W-1:0] in_x_i;
   logic [W-1:0] in_y_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [W-1:0] out_mag_o;
   logic [W-1:0] out_angle_o;

   int n_chk  = 0;
   int n_pass = 0;

   cordic_vector_iter dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_x_i      (in_x_i),
      .in_y_i      (in_y_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_mag_o   (out_mag_o),
      .out_angle_o (out_angle_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string name;
      int    x;
      int    y;
      int    mag;
      int    ang;
      bit    chk_mag;
      int    tol;
   } vec_t;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic check(input string name, input bit ok, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic check_tol(input string name, input int act, input int exp, input int tol);
      check(name, (act - exp <= tol) && (exp - act <= tol), act, exp);
   endtask

   // Present one input when the engine is ready; returns 1 ns after the accept edge
   task automatic send(input int x, input int y);
      int k;
      k = 0;
      @(negedge clk_i);
      while (!in_ready_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      if (k >= 50) check("send_ready", in_ready_o, int'(in_ready_o), 1);
      in_valid_i = 1'b1;
      in_x_i     = W'(x);
      in_y_i     = W'(y);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      in_x_i     = '0;
      in_y_i     = '0;
   endtask

   // Count edges from the accept edge to out_valid; note whether in_ready stayed low meanwhile
   task automatic wait_result(output int lat, output bit ready_low);
      lat       = 0;
      ready_low = 1'b1;
      while (lat < 40) begin
         @(posedge clk_i);
         lat++;
         @(negedge clk_i);
         if (out_valid_o) break;
         if (in_ready_o) ready_low = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[7];
      int   lat;
      bit   rl;
      bit   hold_ok;
      bit   stale_ok;
      int   m0, a0;

      tbl[0] = '{"p1_0",   262144,       0, 431686,       0, 1'b1, 8};
      tbl[1] = '{"p1_p1",  262144,  262144, 610498,  205887, 1'b1, 8};
      tbl[2] = '{"n1_0",  -262144,       0, 431686,  823550, 1'b1, 8};
      tbl[3] = '{"0_n1",        0, -262144,      0, -411775, 1'b0, 8};
      tbl[4] = '{"n1_n1", -262144, -262144,      0, -617662, 1'b0, 8};
      tbl[5] = '{"zero",        0,       0,      0,       0, 1'b1, 0};
      tbl[6] = '{"0_p1",        0,  262144,      0,  411775, 1'b0, 8};

      reset_i     = 1'b1;
      in_valid_i  = 1'b0;
      in_x_i      = '0;
      in_y_i      = '0;
      out_ready_i = 1'b1;

      #12;
      check("rst_in_ready",  in_ready_o,      int'(in_ready_o),   1);
      check("rst_out_valid", !out_valid_o,    int'(out_valid_o),  0);
      check("rst_mag",       out_mag_o == 0,  sx(out_mag_o),      0);
      check("rst_angle",     out_angle_o == 0, sx(out_angle_o),   0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_in_ready", in_ready_o, int'(in_ready_o), 1);

      for (int i = 0; i < 7; i++) begin
         send(tbl[i].x, tbl[i].y);
         wait_result(lat, rl);
         check({tbl[i].name, "_latency"}, lat == 16, lat, 16);
         check({tbl[i].name, "_ready_low"}, rl, int'(rl), 1);
         check_tol({tbl[i].name, "_angle"}, sx(out_angle_o), tbl[i].ang, tbl[i].tol);
         if (tbl[i].chk_mag)
            check_tol({tbl[i].name, "_mag"}, sx(out_mag_o), tbl[i].mag, tbl[i].tol);
         @(posedge clk_i);
         @(negedge clk_i);
         check({tbl[i].name, "_drained"}, !out_valid_o && in_ready_o,
               int'({out_valid_o, in_ready_o}), 1);
      end

      // Backpressure: result held for 10 cycles, then handshake and back-to-back accept
      out_ready_i = 1'b0;
      send(262144, 0);
      wait_result(lat, rl);
      check("bp_latency", lat == 16, lat, 16);
      m0 = sx(out_mag_o);
      a0 = sx(out_angle_o);
      check_tol("bp_mag",   m0, 431686, 8);
      check_tol("bp_angle", a0, 0, 8);
      hold_ok = 1'b1;
      repeat (10) begin
         @(negedge clk_i);
         if (!out_valid_o || in_ready_o || sx(out_mag_o) != m0 || sx(out_angle_o) != a0)
            hold_ok = 1'b0;
      end
      check("bp_hold", hold_ok, int'(hold_ok), 1);
      out_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check("bp_release", !out_valid_o && in_ready_o, int'({out_valid_o, in_ready_o}), 1);
      in_valid_i = 1'b1;
      in_x_i     = W'(262144);
      in_y_i     = W'(262144);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      wait_result(lat, rl);
      check("b2b_latency", lat == 16, lat, 16);
      check("b2b_ready_low", rl, int'(rl), 1);
      check_tol("b2b_angle", sx(out_angle_o), 205887, 8);
      check_tol("b2b_mag",   sx(out_mag_o),   610498, 8);
      @(posedge clk_i);

      // Reset after seven micro-rotations: asynchronous clear, no stale result
      send(262144, 262144);
      repeat (7) @(posedge clk_i);
      #3;
      reset_i = 1'b1;
      #1;
      check("mid_rst_out_valid", !out_valid_o,     int'(out_valid_o), 0);
      check("mid_rst_mag",       out_mag_o == 0,   sx(out_mag_o),     0);
      check("mid_rst_angle",     out_angle_o == 0, sx(out_angle_o),   0);
      check("mid_rst_in_ready",  in_ready_o,       int'(in_ready_o),  1);
      repeat (2) @(negedge clk_i);
      reset_i  = 1'b0;
      stale_ok = 1'b1;
      repeat (25) begin
         @(negedge clk_i);
         if (out_valid_o || !in_ready_o) stale_ok = 1'b0;
      end
      check("mid_rst_no_stale", stale_ok, int'(stale_ok), 1);
      send(-262144, 0);
      wait_result(lat, rl);
      check("fresh_latency", lat == 16, lat, 16);
      check_tol("fresh_angle", sx(out_angle_o), 823550, 8);
      check_tol("fresh_mag",   sx(out_mag_o),   431686, 8);
      @(posedge clk_i);
      @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
